// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller for the MiniAlu core: owns the PC, registers each
// fetched instruction and resolves NOP delays, JMP and BLE locally.
module fetch_sequencer #(
  parameter int unsigned          ADDR_W     = 16,
  parameter int unsigned          DELAY_W    = 24,
  parameter logic [ADDR_W-1:0]    RESET_ADDR = ADDR_W'(0)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iEnable,
  input  logic              iStall,
  input  logic              iBranchTaken,
  input  logic [27:0]       iInstruction,
  output logic [ADDR_W-1:0] oAddress,
  output logic [27:0]       oInstruction,
  output logic              oInstructionValid,
  output logic              oBusy
);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_BLE = 4'd2;
  localparam logic [3:0] OP_JMP = 4'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DELAY,
    S_BRANCH_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DELAY_W-1:0]  count_q, count_d;
  logic [27:0]         instr_q, instr_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   fetch_target;
  logic [ADDR_W-1:0]   branch_target;
  logic [DELAY_W-1:0]  delay;

  assign opcode        = iInstruction[27:24];
  assign fetch_target  = ADDR_W'(iInstruction[23:16]);
  // The BLE being resolved is the one still held in the output register.
  assign branch_target = ADDR_W'(instr_q[23:16]);
  assign delay         = DELAY_W'(iInstruction[23:0]);

  // State and datapath registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_ADDR;
      count_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, next-PC and issue decisions.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    instr_d = instr_q;
    valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iEnable) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!iEnable) begin
          state_d = S_IDLE;
        end else if (!iStall) begin
          instr_d = iInstruction;
          valid_d = 1'b1;
          case (opcode)
            OP_NOP: begin
              pc_d = pc_q + ADDR_W'(1);
              if (delay != '0) begin
                count_d = delay;
                state_d = S_DELAY;
              end
            end
            OP_JMP:  pc_d = fetch_target;
            OP_BLE:  state_d = S_BRANCH_WAIT;
            default: pc_d = pc_q + ADDR_W'(1);
          endcase
        end
      end
      S_DELAY: begin
        count_d = count_q - DELAY_W'(1);
        if (count_q == DELAY_W'(1)) state_d = S_ISSUE;
      end
      S_BRANCH_WAIT: begin
        pc_d    = iBranchTaken ? branch_target : pc_q + ADDR_W'(1);
        state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_DELAY) || (state_d == S_BRANCH_WAIT);
  end

  assign oAddress          = pc_q;
  assign oInstruction      = instr_q;
  assign oInstructionValid = valid_q;
  assign oBusy             = busy_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller for the MiniAlu core. It owns the program counter and drives the address input of the combinational instruction ROM. It registers each 28-bit instruction for the decode/datapath stage. It resolves control flow locally: timed `NOP delays, unconditional `JMP, and `BLE using a compare result returned by the datapath.

Parameters:
ADDR_W, 16, program counter / ROM address width
DELAY_W, 24, width of the `NOP delay operand and delay counter
RESET_ADDR, 16'd0, PC value loaded on reset

Ports:
Clock  input  1  system clock; all state updates on rising edge
Reset  input  1  asynchronous, active-low reset
iEnable  input  1  run enable; fetch proceeds only while high
iStall  input  1  datapath back-pressure; holds fetch in ISSUE
iBranchTaken  input  1  `BLE compare result (Ra <= Rb), valid the cycle after the `BLE is issued
iInstruction  input  28  instruction word returned combinationally by the ROM for oAddress
oAddress  output  ADDR_W  ROM address, equal to the current PC
oInstruction  output  28  registered instruction to decode
oInstructionValid  output  1  one-cycle pulse per issued instruction
oBusy  output  1  high in DELAY or BRANCH_WAIT

Behaviour:
- Fields: opcode = [27:24], decoded against the shared definitions macros; branch/jump target = [23:16], zero-extended to ADDR_W; `NOP delay = [23:0].
- Reset (async, Reset=0): PC=RESET_ADDR, state=IDLE, oInstruction=28'd0, oInstructionValid=0, delay counter=0, oBusy=0. Reset overrides every other input and aborts any state immediately.
- oAddress = PC at all times (registered, no combinational path from inputs).
- IDLE: oInstructionValid=0. iEnable=1 moves to ISSUE next edge; PC is unchanged.
- ISSUE, iEnable=0: go to IDLE, PC held, nothing issued.
- ISSUE, iEnable=1, iStall=1: PC held, oInstructionValid=0, oInstruction held.
- ISSUE, iEnable=1, iStall=0: at the edge, oInstruction<=iInstruction and oInstructionValid<=1. Next PC depends on opcode:
  - `NOP: PC<=PC+1. If delay>0, counter<=delay and go to DELAY. If delay=0, stay in ISSUE.
  - `JMP: PC<=target; stay in ISSUE.
  - `BLE: go to BRANCH_WAIT; PC held.
  - all others (`STO, `ADD, `SUB, `LED, ...): PC<=PC+1.
- DELAY: oBusy=1, oInstructionValid=0. Counter decrements once per cycle; when counter==1, return to ISSUE. A `NOP with delay N occupies 1+N cycles total. iStall and iEnable are ignored until exit.
- BRANCH_WAIT: exactly one cycle, oBusy=1, oInstructionValid=0. iBranchTaken is sampled: 1 sets PC<=target, 0 sets PC<=PC+1. Returns to ISSUE. iStall and iEnable are ignored.
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFF+1 wraps to 16'h0000.
- Unknown opcodes are treated as sequential (PC+1) and still issued.
- Steady-state throughput: one instruction per cycle for sequential code. Each `BLE costs 2 cycles. Each `JMP costs 1 cycle, because its target is fetched on the next edge.

Test Plan:
- Reset/start: hold Reset=0, then release with iEnable=1 -> oAddress=0, first valid pulse carries ROM[0], then addresses 1,2,3 on consecutive cycles.
- NOP delay: ROM[0]={`NOP,24'd3}, ROM[1]={`STO,`R1,16'hcafe} -> valid for NOP; oBusy high for exactly 3 cycles; the next valid pulse carries the STO 4 cycles after the NOP pulse; `NOP with delay 0 -> back-to-back issue.
- Branch: ROM[9]={`BLE,8'd8,`R1,`R2}. iBranchTaken=1 -> next issued address is 8. iBranchTaken=0 -> next issued address is 10. One bubble cycle in both cases.
- JMP and wrap: ROM[14]={`JMP,8'd2,16'b0} -> next address 2. Force PC=16'hFFFF with a sequential opcode -> next address 0.
- Stall/enable: iStall=1 for 5 cycles in ISSUE -> PC and oInstruction frozen, no valid pulses. iEnable=0 mid-program, then 1 -> resumes at the held PC with no skipped or repeated instruction. iStall=1 during DELAY -> delay length unchanged.
- Reset mid-operation: assert Reset during DELAY with counter=2000 -> oBusy=0, oInstructionValid=0 and oAddress=0 immediately, before the next clock edge.
